adc_avg_sequencer: RTL
======================

Name: adc_avg_sequencer

Overview:
- Sits between the synchronised start request and the ADC core in the divided_clock domain.
- Issues repeated conversions to adc_system_top and averages 2^avg_log2 samples per result.
- Writes each averaged result into the write side of the ADC output async FIFO.
- Turns a single SPI start request into a multi-sample burst with result decimation, FIFO-full accounting and an optional conversion watchdog.

Parameters:
DATA_W, 8, width of ADC sample and averaged result
MAX_LOG2_AVG, 4, maximum log2 of samples per result (up to 16 samples); accumulator width DATA_W+MAX_LOG2_AVG
TIMEOUT_CYCLES, 1024, divided_clock cycles allowed in WAIT_VALID (used only with ADC_SEQ_TIMEOUT_EN)

Ports:
divided_clock  input  1  clock for all logic
ADC_CTRL_RESETN  input  1  asynchronous active-low reset
start_level  input  1  synchronised start request level; rising edge launches a run
avg_log2  input  3  log2 samples per result; values above MAX_LOG2_AVG clamp to MAX_LOG2_AVG
burst_len  input  8  results per run; 0 = continuous while start_level high
adc_start  output  1  conversion request to adc_system_top
adc_busy  input  1  ADC core busy
adc_value  input  DATA_W  conversion result
adc_valid  input  1  one-cycle strobe qualifying adc_value
fifo_data  output  DATA_W  averaged result to FIFO data_in
fifo_wr  output  1  one-cycle FIFO write strobe
fifo_full  input  1  FIFO full
seq_busy  output  1  high whenever state != IDLE
drop_count  output  8  results discarded because FIFO full; saturates at 255
timeout_flag  output  1  sticky watchdog flag (tied 0 without macro)

Behaviour:
- Reset is ADC_CTRL_RESETN, asynchronous, active-low; clock is divided_clock.
- Reset (including mid-run) forces: state IDLE; adc_start, fifo_wr, seq_busy, timeout_flag = 0; fifo_data, drop_count, accumulator, sample/result counters = 0; start_q = 0.
- All outputs are registered.
- Edge detect: start_q <= start_level each cycle. Edge = start_level & !start_q, honoured only in IDLE.
- avg_log2 and burst_len are latched at the edge; changes during a run are ignored.
- IDLE: on edge -> ISSUE; clear accumulator and counters.
- ISSUE:
  - adc_start = 1 while in ISSUE.
  - Stays in ISSUE until adc_busy = 1 is sampled, then -> WAIT_VALID with adc_start = 0.
  - adc_start is therefore high for at least 1 cycle.
- WAIT_VALID: on adc_valid, acc += adc_value, sample_cnt++. If sample_cnt reaches 2^n -> OUTPUT, else -> ISSUE. adc_valid in any other state is ignored.
- OUTPUT (exactly one cycle):
  - Result = (acc + 2^(n-1)) >> n for n > 0; result = acc for n = 0. Max result 2^DATA_W-1, so no overflow is possible.
  - If !fifo_full: fifo_wr = 1 for this cycle and fifo_data = result; fifo_data holds its value afterwards.
  - If fifo_full: no write; drop_count++ (saturating). Sampling cadence is preserved.
  - result_cnt++; acc and sample_cnt cleared.
  - Next state:
    - burst_len != 0 and result_cnt == burst_len -> IDLE.
    - burst_len == 0 and start_level == 0 -> IDLE.
    - Otherwise -> ISSUE.
- Finite runs (burst_len != 0) ignore start_level falling.
- A new rising edge during a run is ignored; an edge during the last OUTPUT cycle is not captured.
- drop_count is cleared only by reset.
- Latency, edge sampled at clock k:
  - ISSUE is entered and adc_start goes high after edge k+1.
  - With n = 0, the first fifo_wr occurs 2 cycles after the adc_valid sample edge (WAIT_VALID -> OUTPUT register, then write registered).

Optional Feature:
- Macro: ADC_SEQ_TIMEOUT_EN.
- With macro:
  - A counter runs in WAIT_VALID and in ISSUE.
  - If it reaches TIMEOUT_CYCLES without progress (adc_busy in ISSUE, adc_valid in WAIT_VALID), timeout_flag sets (sticky until reset).
  - The run aborts: partial accumulator discarded, no FIFO write, state -> IDLE, adc_start = 0.
- Without macro:
  - No counter; the sequencer waits indefinitely.
  - timeout_flag is constant 0.

Test Plan:
- avg_log2=0, burst_len=3, ADC model returns 0x10,0x20,0x30 -> three fifo_wr pulses with data 0x10,0x20,0x30; seq_busy falls after third; adc_start pulsed 3 times.
- avg_log2=2, burst_len=1, samples 1,2,3,4 -> single write of 0x03 ((10+2)>>2); samples 0xFF×4 -> 0xFF.
- avg_log2=7 (clamped to 4), burst_len=1, sixteen 0x08 samples -> 16 adc_start pulses, one write of 0x08.
- burst_len=0, start_level held high for 5 results then dropped mid-conversion -> current result completes and is written, then IDLE; total 6 writes.
- fifo_full=1 throughout, avg_log2=0, burst_len=4 -> zero fifo_wr, drop_count=4; 300-result continuous run -> drop_count saturates at 255.
- Reset asserted while in WAIT_VALID -> adc_start, fifo_wr, seq_busy low immediately; with ADC_SEQ_TIMEOUT_EN and adc_valid never asserted, timeout_flag=1 after 1024 cycles, no write, state IDLE.

Source files
------------

// File: rtl/adc_avg_sequencer.sv
// Burst/averaging conversion sequencer between the start request, the ADC core and the output FIFO.
// Optional conversion watchdog enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_avg_sequencer #(
    parameter int DATA_W         = 8,
    parameter int MAX_LOG2_AVG   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              divided_clock,
    input  logic              ADC_CTRL_RESETN,
    input  logic              start_level,
    input  logic [2:0]        avg_log2,
    input  logic [7:0]        burst_len,
    output logic              adc_start,
    input  logic              adc_busy,
    input  logic [DATA_W-1:0] adc_value,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_wr,
    input  logic              fifo_full,
    output logic              seq_busy,
    output logic [7:0]        drop_count,
    output logic              timeout_flag
);
    localparam int ACC_W = DATA_W + MAX_LOG2_AVG;
    localparam int CNT_W = MAX_LOG2_AVG + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_VALID, S_OUTPUT} state_e;

    state_e            state_q, state_d;
    logic              start_q;
    logic [2:0]        n_q, n_d;
    logic [7:0]        burst_q, burst_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [7:0]        result_cnt_q, result_cnt_d;
    logic              adc_start_q, seq_busy_q;
    logic              fifo_wr_q, fifo_wr_d;
    logic [DATA_W-1:0] fifo_data_q, fifo_data_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              timeout_q, timeout_d;
    logic              start_edge;
    logic              watchdog_expired;
    logic [CNT_W-1:0]  samples_needed;
    logic [ACC_W-1:0]  round_sum;
    logic [DATA_W-1:0] result;

    assign start_edge     = start_level & ~start_q;
    assign samples_needed = CNT_W'(1) << n_q;
    // Round-to-nearest: add half an LSB of the shifted result before dividing.
    assign round_sum      = acc_q + ((n_q == 3'd0) ? '0 : (ACC_W'(1) << (n_q - 3'd1)));
    assign result         = DATA_W'(round_sum >> n_q);

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    // Counts consecutive stalled cycles; any handshake progress restarts it.
    always_comb begin
        wd_d             = '0;
        watchdog_expired = 1'b0;
        if ((state_q == S_ISSUE && !adc_busy) || (state_q == S_WAIT_VALID && !adc_valid)) begin
            wd_d             = wd_q + WD_W'(1);
            watchdog_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge divided_clock or negedge ADC_CTRL_RESETN) begin
        if (!ADC_CTRL_RESETN) wd_q <= '0;
        else                  wd_q <= wd_d;
    end
`else
    assign watchdog_expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        burst_d      = burst_q;
        acc_d        = acc_q;
        sample_cnt_d = sample_cnt_q;
        result_cnt_d = result_cnt_q;
        fifo_wr_d    = 1'b0;
        fifo_data_d  = fifo_data_q;
        drop_cnt_d   = drop_cnt_q;
        timeout_d    = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d      = S_ISSUE;
                    n_d          = (avg_log2 > 3'(MAX_LOG2_AVG)) ? 3'(MAX_LOG2_AVG) : avg_log2;
                    burst_d      = burst_len;
                    acc_d        = '0;
                    sample_cnt_d = '0;
                    result_cnt_d = '0;
                end
            end
            S_ISSUE: begin
                if (adc_busy) state_d = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (adc_valid) begin
                    acc_d        = acc_q + ACC_W'(adc_value);
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    state_d      = (sample_cnt_d == samples_needed) ? S_OUTPUT : S_ISSUE;
                end
            end
            S_OUTPUT: begin
                if (!fifo_full) begin
                    fifo_wr_d   = 1'b1;
                    fifo_data_d = result;
                end else if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
                result_cnt_d = result_cnt_q + 8'd1;
                acc_d        = '0;
                sample_cnt_d = '0;
                if (burst_q != 8'd0) state_d = (result_cnt_d == burst_q) ? S_IDLE : S_ISSUE;
                else                 state_d = start_level ? S_ISSUE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A stalled conversion abandons the whole run, including the partial sum.
        if (watchdog_expired) begin
            state_d      = S_IDLE;
            acc_d        = '0;
            sample_cnt_d = '0;
            timeout_d    = 1'b1;
        end
    end

    always_ff @(posedge divided_clock or negedge ADC_CTRL_RESETN) begin
        if (!ADC_CTRL_RESETN) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            n_q          <= '0;
            burst_q      <= '0;
            acc_q        <= '0;
            sample_cnt_q <= '0;
            result_cnt_q <= '0;
            adc_start_q  <= 1'b0;
            seq_busy_q   <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= '0;
            drop_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_level;
            n_q          <= n_d;
            burst_q      <= burst_d;
            acc_q        <= acc_d;
            sample_cnt_q <= sample_cnt_d;
            result_cnt_q <= result_cnt_d;
            adc_start_q  <= (state_d == S_ISSUE);
            seq_busy_q   <= (state_d != S_IDLE);
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
            drop_cnt_q   <= drop_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign adc_start    = adc_start_q;
    assign seq_busy     = seq_busy_q;
    assign fifo_wr      = fifo_wr_q;
    assign fifo_data    = fifo_data_q;
    assign drop_count   = drop_cnt_q;
    assign timeout_flag = timeout_q;

endmodule
